// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen geometry, fixed-point format and motion FSM encoding
//
// Purpose: constants shared by the player motion block, the VGA controller
// and the target generator.
// Contents: screen size, player half-extent, fixed-point fraction width,
// step limits, centre coordinates and the motion FSM state encoding.
package game_pkg;

  localparam int WIDTH     = 640;
  localparam int HEIGHT    = 480;
  localparam int HALF_SIZE = 25;
  localparam int FRAC_BITS = 4;
  localparam int MAX_STEP  = 8;
  localparam int BTN_STEP  = 2;

  localparam int CENTRE_X  = WIDTH / 2;
  localparam int CENTRE_Y  = HEIGHT / 2;

  typedef logic [1:0] motion_state_t;

  localparam motion_state_t S_IDLE   = 2'd0;
  localparam motion_state_t S_STEP   = 2'd1;
  localparam motion_state_t S_INTEG  = 2'd2;
  localparam motion_state_t S_COMMIT = 2'd3;

endpackage

// File: rtl/player_motion_if.sv
// rtl/player_motion_if.sv - input/output bundle of the player motion integrator
//
// Purpose: groups the frame strobe, control levels, tilt, buttons and the
// committed position outputs of player_motion.
// Signals:
//   screenEnd, enable, recenter          control from timing generator / game
//   tilt_x, tilt_y                       signed tilt, 1/16 px per frame
//   BTNU, BTND, BTNL, BTNR               raw asynchronous push-buttons
//   accel_x, accel_y                     committed player centre, integer px
//   frame_tick                           one-cycle commit pulse
//   at_edge                              {top, bottom, left, right} clamp flags
// Modports: master drives the inputs (system side), slave is player_motion.
interface player_motion_if;

  logic               screenEnd;
  logic               enable;
  logic               recenter;
  logic signed [11:0] tilt_x;
  logic signed [11:0] tilt_y;
  logic               BTNU;
  logic               BTND;
  logic               BTNL;
  logic               BTNR;
  logic [31:0]        accel_x;
  logic [31:0]        accel_y;
  logic               frame_tick;
  logic [3:0]         at_edge;

  modport master (
    output screenEnd, enable, recenter, tilt_x, tilt_y,
    output BTNU, BTND, BTNL, BTNR,
    input  accel_x, accel_y, frame_tick, at_edge
  );

  modport slave (
    input  screenEnd, enable, recenter, tilt_x, tilt_y,
    input  BTNU, BTND, BTNL, BTNR,
    output accel_x, accel_y, frame_tick, at_edge
  );

endinterface

// File: rtl/axis_integrator.sv
// rtl/axis_integrator.sv - per-axis step saturation, position accumulate and clamp
//
// Purpose: holds one axis of the player centre in fixed point and advances it
// by a saturated per-frame step, keeping the player box fully on screen.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   do_step             register the saturated step (tilt + button term)
//   do_integ            add the step to the position and clamp
//   recenter            forces a zero step and loads the centre
//   tilt                signed tilt, 1/16 px per frame
//   dir_pos, dir_neg    button direction for this axis
//   pos_fx              position, 14-bit unsigned fixed point
//   at_min, at_max      position sits exactly on the low/high clamp limit
module axis_integrator
  import game_pkg::*;
#(
  parameter int LIMIT     = 640,
  parameter int HALF_SIZE = 25,
  parameter int FRAC_BITS = 4,
  parameter int MAX_STEP  = 8,
  parameter int BTN_STEP  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               do_step,
  input  logic               do_integ,
  input  logic               recenter,
  input  logic signed [11:0] tilt,
  input  logic               dir_pos,
  input  logic               dir_neg,
  output logic [13:0]        pos_fx,
  output logic               at_min,
  output logic               at_max
);

  localparam logic signed [15:0] STEP_MAX   = 16'(MAX_STEP << FRAC_BITS);
  localparam logic signed [15:0] STEP_MIN   = -STEP_MAX;
  localparam logic signed [15:0] BTN_INC    = 16'(BTN_STEP << FRAC_BITS);
  localparam logic signed [15:0] POS_MIN    = 16'(HALF_SIZE << FRAC_BITS);
  localparam logic signed [15:0] POS_MAX    = 16'((LIMIT - 1 - HALF_SIZE) << FRAC_BITS);
  localparam logic [13:0]        POS_MIN_U  = 14'(HALF_SIZE << FRAC_BITS);
  localparam logic [13:0]        POS_MAX_U  = 14'((LIMIT - 1 - HALF_SIZE) << FRAC_BITS);
  localparam logic [13:0]        POS_CENTRE = 14'((LIMIT / 2) << FRAC_BITS);

  logic signed [15:0] btn_term;
  logic signed [15:0] step_raw;
  logic signed [15:0] step_sat;
  logic signed [15:0] step_q;
  logic signed [15:0] sum;
  logic [13:0]        pos_next;

  always_comb begin
    btn_term = 16'sd0;
    // Opposing buttons cancel on the axis.
    if (dir_pos && !dir_neg) begin
      btn_term = BTN_INC;
    end else if (dir_neg && !dir_pos) begin
      btn_term = -BTN_INC;
    end
    step_raw = $signed({{4{tilt[11]}}, tilt}) + btn_term;
    step_sat = step_raw;
    if (step_raw > STEP_MAX) begin
      step_sat = STEP_MAX;
    end else if (step_raw < STEP_MIN) begin
      step_sat = STEP_MIN;
    end
  end

  always_comb begin
    sum      = $signed({2'b00, pos_fx}) + step_q;
    pos_next = sum[13:0];
    if (sum < POS_MIN) begin
      pos_next = POS_MIN_U;
    end else if (sum > POS_MAX) begin
      pos_next = POS_MAX_U;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= 16'sd0;
      pos_fx <= POS_CENTRE;
    end else begin
      if (do_step) begin
        step_q <= recenter ? 16'sd0 : step_sat;
      end
      if (do_integ) begin
        pos_fx <= recenter ? POS_CENTRE : pos_next;
      end
    end
  end

  assign at_min = (pos_fx == POS_MIN_U);
  assign at_max = (pos_fx == POS_MAX_U);

endmodule

// File: rtl/player_motion.sv
// rtl/player_motion.sv - per-frame player position integrator feeding the VGA controller
//
// Purpose: once per frame (screenEnd rising edge) combines tilt and buttons
// into a saturated step, integrates it into the player centre, clamps it on
// screen and commits both coordinates together.
// Ports:
//   clk_25mHz   pixel clock
//   reset       synchronous, active-high
//   bus         player_motion_if.slave: screenEnd, enable, recenter, tilt_x/y,
//               BTNU/D/L/R in; accel_x/y, frame_tick, at_edge out
module player_motion
  import game_pkg::*;
#(
  parameter int WIDTH     = game_pkg::WIDTH,
  parameter int HEIGHT    = game_pkg::HEIGHT,
  parameter int HALF_SIZE = game_pkg::HALF_SIZE,
  parameter int FRAC_BITS = game_pkg::FRAC_BITS,
  parameter int MAX_STEP  = game_pkg::MAX_STEP,
  parameter int BTN_STEP  = game_pkg::BTN_STEP
) (
  input  logic           clk_25mHz,
  input  logic           reset,
  player_motion_if.slave bus
);

  // Button order everywhere below: {U, D, L, R}.
  logic [3:0]    btn_meta;
  logic [3:0]    btn_sync;
  logic [3:0]    btn_lat;
  logic          recenter_lat;

  logic          screen_end_q;
  logic          tick_q;

  motion_state_t state;
  motion_state_t state_next;
  logic          take_tick;
  logic          do_step;
  logic          do_integ;
  logic          do_commit;

  logic [13:0]   pos_x_fx;
  logic [13:0]   pos_y_fx;
  logic          x_min, x_max, y_min, y_max;

  logic [9:0]    accel_x_q;
  logic [9:0]    accel_y_q;
  logic [3:0]    at_edge_q;
  logic          frame_tick_q;

  always_ff @(posedge clk_25mHz) begin
    if (reset) begin
      btn_meta <= 4'b0;
      btn_sync <= 4'b0;
    end else begin
      btn_meta <= {bus.BTNU, bus.BTND, bus.BTNL, bus.BTNR};
      btn_sync <= btn_meta;
    end
  end

  // The edge register resets high so a strobe already asserted when reset
  // releases is not mistaken for a new frame. The tick itself is registered,
  // giving the one-cycle edge stage ahead of the FSM.
  always_ff @(posedge clk_25mHz) begin
    if (reset) begin
      screen_end_q <= 1'b1;
      tick_q       <= 1'b0;
    end else begin
      screen_end_q <= bus.screenEnd;
      tick_q       <= bus.screenEnd & ~screen_end_q;
    end
  end

  always_ff @(posedge clk_25mHz) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (tick_q && bus.enable) state_next = S_STEP;
      S_STEP:   state_next = S_INTEG;
      S_INTEG:  state_next = S_COMMIT;
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    take_tick = (state == S_IDLE) && tick_q && bus.enable;
    do_step   = (state == S_STEP);
    do_integ  = (state == S_INTEG);
    do_commit = (state == S_COMMIT);
  end

  // Buttons and recenter are captured when the tick is accepted so that the
  // whole update uses one consistent snapshot.
  always_ff @(posedge clk_25mHz) begin
    if (reset) begin
      btn_lat      <= 4'b0;
      recenter_lat <= 1'b0;
    end else if (take_tick) begin
      btn_lat      <= btn_sync;
      recenter_lat <= bus.recenter;
    end
  end

  axis_integrator #(
    .LIMIT     (WIDTH),
    .HALF_SIZE (HALF_SIZE),
    .FRAC_BITS (FRAC_BITS),
    .MAX_STEP  (MAX_STEP),
    .BTN_STEP  (BTN_STEP)
  ) u_axis_x (
    .clk      (clk_25mHz),
    .reset    (reset),
    .do_step  (do_step),
    .do_integ (do_integ),
    .recenter (recenter_lat),
    .tilt     (bus.tilt_x),
    .dir_pos  (btn_lat[0]),
    .dir_neg  (btn_lat[1]),
    .pos_fx   (pos_x_fx),
    .at_min   (x_min),
    .at_max   (x_max)
  );

  axis_integrator #(
    .LIMIT     (HEIGHT),
    .HALF_SIZE (HALF_SIZE),
    .FRAC_BITS (FRAC_BITS),
    .MAX_STEP  (MAX_STEP),
    .BTN_STEP  (BTN_STEP)
  ) u_axis_y (
    .clk      (clk_25mHz),
    .reset    (reset),
    .do_step  (do_step),
    .do_integ (do_integ),
    .recenter (recenter_lat),
    .tilt     (bus.tilt_y),
    .dir_pos  (btn_lat[2]),
    .dir_neg  (btn_lat[3]),
    .pos_fx   (pos_y_fx),
    .at_min   (y_min),
    .at_max   (y_max)
  );

  // Outputs only move in the commit cycle, so both axes update on one edge.
  always_ff @(posedge clk_25mHz) begin
    if (reset) begin
      accel_x_q    <= 10'((WIDTH / 2));
      accel_y_q    <= 10'((HEIGHT / 2));
      at_edge_q    <= 4'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= do_commit;
      if (do_commit) begin
        accel_x_q <= pos_x_fx[13:4];
        accel_y_q <= pos_y_fx[13:4];
        at_edge_q <= {y_min, y_max, x_min, x_max};
      end
    end
  end

  assign bus.accel_x    = {22'b0, accel_x_q};
  assign bus.accel_y    = {22'b0, accel_y_q};
  assign bus.at_edge    = at_edge_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
